// File: rtl/adc_capture_gate_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_capture_gate_pkg                                      |
// | Brief    : Shared types, lane geometry and data mask helper for the  |
// |            ADC capture gate.                                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package adc_capture_gate_pkg;

    localparam int NSAMP    = 8;
    localparam int SAMPBITS = 12;
    localparam int LANEBITS = 16;
    localparam int DATAW    = NSAMP * LANEBITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GATE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Samples sit in the top SAMPBITS of each lane; the low bits carry no data.
    function automatic logic [DATAW-1:0] zero_low_nibbles(input logic [DATAW-1:0] d);
        logic [DATAW-1:0] r;
        r = d;
        for (int i = 0; i < NSAMP; i++) begin
            r[LANEBITS*i +: (LANEBITS-SAMPBITS)] = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_capture_gate_trigger_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : capture_trigger_sync                                      |
// | Brief    : Two-flop synchroniser for capture_i plus rising-edge      |
// |            detect; one trigger per request however long it is held. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module capture_trigger_sync (
    input  logic aclk,
    input  logic aresetn,
    input  logic capture_i,
    output logic trig_o
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= capture_i;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    // Decoded from flops only, so the pulse is clean for the FSM's third edge.
    assign trig_o = r_sync & ~r_sync_d;

endmodule
`default_nettype wire

// File: rtl/adc_capture_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : adc_capture_gate                                          |
// | Brief    : Waits a programmable delay after a capture request, then  |
// |            passes a fixed-length window of ADC data, zeros otherwise.|
// |            ADC_CAPTURE_GATE_TLAST_EN adds m_tlast and first_o.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module adc_capture_gate
    import adc_capture_gate_pkg::*;
#(
    parameter int NBEATS_W       = 16,
    parameter int DEFAULT_DELAY  = 32,
    parameter int DEFAULT_LENGTH = 32,
    parameter int HOLDOFF        = 64
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                capture_i,
    input  logic [NBEATS_W-1:0] delay_i,
    input  logic [NBEATS_W-1:0] length_i,
    input  logic [127:0]        s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [127:0]        m_tdata,
    output logic                m_tvalid,
    output logic                busy_o,
    output logic                done_o,
    output logic [7:0]          drop_count_o
`ifdef ADC_CAPTURE_GATE_TLAST_EN
    ,
    output logic                m_tlast,
    output logic                first_o
`endif
);

    localparam logic [NBEATS_W-1:0] c_one       = NBEATS_W'(1);
    localparam logic [NBEATS_W-1:0] c_holdoff   = NBEATS_W'(HOLDOFF);
    localparam logic [NBEATS_W-1:0] c_def_delay = NBEATS_W'(DEFAULT_DELAY);
    localparam logic [NBEATS_W-1:0] c_def_len   = NBEATS_W'(DEFAULT_LENGTH);

    logic                w_trig;
    logic                w_last;
    logic [NBEATS_W-1:0] w_delay_sel;
    logic [NBEATS_W-1:0] w_len_sel;

    state_t              r_state;
    logic [NBEATS_W-1:0] r_cnt;
    logic [NBEATS_W-1:0] r_len;

    capture_trigger_sync u_trigger_sync (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .capture_i (capture_i),
        .trig_o    (w_trig)
    );

    assign w_last      = (r_cnt == c_one);
    assign w_delay_sel = (delay_i  == '0) ? c_def_delay : delay_i;
    assign w_len_sel   = (length_i == '0) ? c_def_len   : length_i;

    // One counter serves all three timed phases; each phase ends when it reads 1.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_len        <= '0;
            s_tready     <= 1'b0;
            m_tvalid     <= 1'b0;
            m_tdata      <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            drop_count_o <= '0;
`ifdef ADC_CAPTURE_GATE_TLAST_EN
            m_tlast      <= 1'b0;
            first_o      <= 1'b0;
`endif
        end else begin
            s_tready <= 1'b1;
            m_tvalid <= 1'b1;
            done_o   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_cnt   <= w_delay_sel;
                        r_len   <= w_len_sel;
                        r_state <= DELAY;
                        busy_o  <= 1'b1;
                    end
                end
                DELAY: begin
                    if (w_last) begin
                        r_cnt   <= r_len;
                        r_state <= GATE;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                GATE: begin
                    if (w_last) begin
                        r_cnt   <= c_holdoff;
                        r_state <= HOLD;
                        done_o  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                HOLD: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase

            if (w_trig && (r_state != IDLE) && (drop_count_o != 8'hFF)) begin
                drop_count_o <= drop_count_o + 8'd1;
            end

            m_tdata <= ((r_state == GATE) && s_tvalid) ? zero_low_nibbles(s_tdata) : '0;
`ifdef ADC_CAPTURE_GATE_TLAST_EN
            m_tlast <= (r_state == GATE) && w_last;
            first_o <= (r_state == GATE) && (r_cnt == r_len);
`endif
        end
    end

endmodule
`default_nettype wire
